// File: rtl/instruction_decode.sv
// LEGv8 decode stage: decodes the IF/ID instruction, reads the 32x64 register file
// (X31 reads as zero), detects RAW hazards and loads the ID/EX pipeline register.
module instruction_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [63:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        flush,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_reg,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_reg,
  input  logic [63:0] wb_data,
  output logic        stall,
  output logic [63:0] Address,
  output logic [31:0] Instruction,
  output logic [63:0] signExtInstr,
  output logic [63:0] Data1,
  output logic [63:0] Data2,
  output logic [1:0]  ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        B,
  output logic        BZ,
  output logic        BNZ,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ex_valid,
  output logic        illegal
);

  logic [63:0] regs [0:31];

  logic        is_b, is_cbz, is_cbnz, is_addi, is_ldur, is_stur, is_rtype, legal;
  logic [4:0]  rn_idx, rm_idx;
  logic        rn_used, rm_used, rn_hit, rm_hit, hz;
  logic [63:0] rn_data, rm_data, imm;
  logic [1:0]  d_alusrc, d_aluop;
  logic        d_b, d_bz, d_bnz, d_memwrite, d_memread, d_memtoreg, d_regwrite;

  assign is_b     = (if_instr[31:26] == 6'b000101);
  assign is_cbz   = (if_instr[31:24] == 8'b10110100);
  assign is_cbnz  = (if_instr[31:24] == 8'b10110101);
  assign is_addi  = (if_instr[31:22] == 10'b1001000100) || (if_instr[31:22] == 10'b1101000100);
  assign is_ldur  = (if_instr[31:21] == 11'b11111000010);
  assign is_stur  = (if_instr[31:21] == 11'b11111000000);
  assign is_rtype = (if_instr[31:21] == 11'b10001011000) || (if_instr[31:21] == 11'b11001011000) ||
                    (if_instr[31:21] == 11'b10001010000) || (if_instr[31:21] == 11'b10101010000);
  assign legal    = is_b | is_cbz | is_cbnz | is_addi | is_ldur | is_stur | is_rtype;

  // Stores and compare-branches carry their second operand in the Rt field.
  assign rn_idx  = if_instr[9:5];
  assign rm_idx  = (is_stur | is_cbz | is_cbnz) ? if_instr[4:0] : if_instr[20:16];
  assign rn_used = ~(is_b | is_cbz | is_cbnz);
  assign rm_used = is_rtype | is_stur | is_cbz | is_cbnz;

  always_comb begin
    d_b        = 1'b0;
    d_bz       = 1'b0;
    d_bnz      = 1'b0;
    d_memwrite = 1'b0;
    d_memread  = 1'b0;
    d_memtoreg = 1'b0;
    d_regwrite = 1'b0;
    d_alusrc   = 2'b00;
    d_aluop    = 2'b00;
    imm        = 64'd0;
    if (is_b) begin
      d_b = 1'b1;
      imm = {{38{if_instr[25]}}, if_instr[25:0]};
    end else if (is_cbz | is_cbnz) begin
      d_bz    = is_cbz;
      d_bnz   = is_cbnz;
      d_aluop = 2'b01;
      imm     = {{45{if_instr[23]}}, if_instr[23:5]};
    end else if (is_addi) begin
      d_alusrc   = 2'b10;
      d_aluop    = 2'b10;
      d_regwrite = 1'b1;
      imm        = {52'd0, if_instr[21:10]};
    end else if (is_ldur) begin
      d_alusrc   = 2'b01;
      d_memread  = 1'b1;
      d_memtoreg = 1'b1;
      d_regwrite = 1'b1;
      imm        = {{55{if_instr[20]}}, if_instr[20:12]};
    end else if (is_stur) begin
      d_alusrc   = 2'b01;
      d_memwrite = 1'b1;
      imm        = {{55{if_instr[20]}}, if_instr[20:12]};
    end else if (is_rtype) begin
      d_aluop    = 2'b10;
      d_regwrite = 1'b1;
    end
  end

  // Same-cycle writeback is forwarded so the reader never sees the stale value.
  always_comb begin
    if (rn_idx == 5'd31)                        rn_data = 64'd0;
    else if (wb_reg_write && wb_reg == rn_idx)  rn_data = wb_data;
    else                                        rn_data = regs[rn_idx];
    if (rm_idx == 5'd31)                        rm_data = 64'd0;
    else if (wb_reg_write && wb_reg == rm_idx)  rm_data = wb_data;
    else                                        rm_data = regs[rm_idx];
  end

  assign rn_hit = rn_used && (rn_idx != 5'd31) &&
                  ((ex_valid && RegWrite && Instruction[4:0] == rn_idx) ||
                   (mem_reg_write && mem_reg == rn_idx));
  assign rm_hit = rm_used && (rm_idx != 5'd31) &&
                  ((ex_valid && RegWrite && Instruction[4:0] == rm_idx) ||
                   (mem_reg_write && mem_reg == rm_idx));
  assign hz     = if_valid & ~reset & (rn_hit | rm_hit);
  assign stall  = hz & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
    end else if (wb_reg_write && wb_reg != 5'd31) begin
      regs[wb_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush || stall || !if_valid) begin
      Address      <= 64'd0;
      Instruction  <= 32'd0;
      signExtInstr <= 64'd0;
      Data1        <= 64'd0;
      Data2        <= 64'd0;
      ALUSrc       <= 2'b00;
      ALUOp        <= 2'b00;
      B            <= 1'b0;
      BZ           <= 1'b0;
      BNZ          <= 1'b0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
      MemtoReg     <= 1'b0;
      RegWrite     <= 1'b0;
      ex_valid     <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      Address      <= if_pc;
      Instruction  <= if_instr;
      signExtInstr <= imm;
      Data1        <= rn_data;
      Data2        <= rm_data;
      ALUSrc       <= d_alusrc;
      ALUOp        <= d_aluop;
      B            <= d_b;
      BZ           <= d_bz;
      BNZ          <= d_bnz;
      MemWrite     <= d_memwrite;
      MemRead      <= d_memread;
      MemtoReg     <= d_memtoreg;
      RegWrite     <= d_regwrite;
      ex_valid     <= 1'b1;
      illegal      <= ~legal;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode, register file, bypass, interlock,
// flush, illegal opcodes and reset behaviour.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset, if_valid, flush, mem_reg_write, wb_reg_write;
  logic [63:0] if_pc, wb_data;
  logic [31:0] if_instr;
  logic [4:0]  mem_reg, wb_reg;
  logic        stall;
  logic [63:0] Address, signExtInstr, Data1, Data2;
  logic [31:0] Instruction;
  logic [1:0]  ALUSrc, ALUOp;
  logic        B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite, ex_valid, illegal;

  int checks = 0;
  int errors = 0;

  // {B,BZ,BNZ,MemWrite,MemRead,MemtoReg,RegWrite,ALUSrc,ALUOp}
  logic [10:0] ctrl;
  assign ctrl = {B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite, ALUSrc, ALUOp};

  localparam logic [10:0] C_NONE = 11'b0000000_00_00;
  localparam logic [10:0] C_ADD  = 11'b0000001_00_10;
  localparam logic [10:0] C_LDUR = 11'b0000111_01_00;
  localparam logic [10:0] C_STUR = 11'b0001000_01_00;
  localparam logic [10:0] C_CBZ  = 11'b0100000_00_01;
  localparam logic [10:0] C_ADDI = 11'b0000001_10_10;
  localparam logic [10:0] C_B    = 11'b1000000_00_00;

  // Hand-assembled instruction words
  localparam logic [31:0] I_ADD_X2_X1_X1  = {11'b10001011000, 5'd1, 6'd0, 5'd1, 5'd2};
  localparam logic [31:0] I_LDUR_X3_X1_M8 = {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd3};
  localparam logic [31:0] I_ADD_X4_X3_X1  = {11'b10001011000, 5'd1, 6'd0, 5'd3, 5'd4};
  localparam logic [31:0] I_CBZ_X5_M2     = {8'b10110100, 19'h7FFFE, 5'd5};
  localparam logic [31:0] I_STUR_X1_X2_16 = {11'b11111000000, 9'd16, 2'b00, 5'd2, 5'd1};
  localparam logic [31:0] I_ADDI_X0_XZR   = {10'b1001000100, 12'hFFF, 5'd31, 5'd0};
  localparam logic [31:0] I_ADD_XZR_X1_X1 = {11'b10001011000, 5'd1, 6'd0, 5'd1, 5'd31};
  localparam logic [31:0] I_ADD_X6_XZR    = {11'b10001011000, 5'd31, 6'd0, 5'd31, 5'd6};
  localparam logic [31:0] I_B_M1          = {6'b000101, 26'h3FFFFFF};

  instruction_decode dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .flush(flush), .mem_reg_write(mem_reg_write), .mem_reg(mem_reg),
    .wb_reg_write(wb_reg_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .stall(stall), .Address(Address), .Instruction(Instruction), .signExtInstr(signExtInstr),
    .Data1(Data1), .Data2(Data2), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .B(B), .BZ(BZ), .BNZ(BNZ),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ex_valid(ex_valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0; if_pc = 64'd0; if_instr = 32'd0; flush = 1'b0;
    mem_reg_write = 1'b0; mem_reg = 5'd0;
    wb_reg_write = 1'b0; wb_reg = 5'd0; wb_data = 64'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    if_valid = 1'b1; if_instr = I_ADD_X2_X1_X1; mem_reg_write = 1'b1; mem_reg = 5'd1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
    checks++; if (ctrl !== C_NONE) begin errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_NONE); end
    checks++; if ({Data1, Data2, Address} !== 192'd0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_data: got %h %h %h ill=%b want zeros", Data1, Data2, Address, illegal);
    end
    reset = 1'b0;
    idle_inputs();
    #1;
    $display("reset: stall=%b ex_valid=%b ctrl=%b", stall, ex_valid, ctrl);
  endtask

  task automatic test_writeback_add();
    wb_reg_write = 1'b1; wb_reg = 5'd1; wb_data = 64'd5;
    tick();
    wb_reg_write = 1'b0;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL idle_bubble: got %b want 0", ex_valid); end
    if_valid = 1'b1; if_pc = 64'h100; if_instr = I_ADD_X2_X1_X1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_stall: got %b want 0", stall); end
    tick();
    checks++; if (Data1 !== 64'd5 || Data2 !== 64'd5) begin
      errors++; $display("FAIL add_data: got %h %h want 5 5", Data1, Data2);
    end
    checks++; if (ctrl !== C_ADD || ex_valid !== 1'b1) begin
      errors++; $display("FAIL add_ctrl: got %b v=%b want %b v=1", ctrl, ex_valid, C_ADD);
    end
    checks++; if (Address !== 64'h100 || Instruction !== I_ADD_X2_X1_X1) begin
      errors++; $display("FAIL add_pc: got %h %h want 100 %h", Address, Instruction, I_ADD_X2_X1_X1);
    end
    $display("add: Data1=%h Data2=%h ctrl=%b", Data1, Data2, ctrl);
  endtask

  task automatic test_load_use();
    if_pc = 64'h104; if_instr = I_LDUR_X3_X1_M8;
    tick();
    checks++; if (signExtInstr !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      errors++; $display("FAIL ldur_imm: got %h want fffffffffffffff8", signExtInstr);
    end
    checks++; if (ctrl !== C_LDUR || Data1 !== 64'd5) begin
      errors++; $display("FAIL ldur_ctrl: got %b d1=%h want %b d1=5", ctrl, Data1, C_LDUR);
    end
    if_pc = 64'h108; if_instr = I_ADD_X4_X3_X1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_ex: got %b want 1", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ctrl !== C_NONE) begin
      errors++; $display("FAIL lu_bubble1: got v=%b ctrl=%b want bubble", ex_valid, ctrl);
    end
    mem_reg_write = 1'b1; mem_reg = 5'd3;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_mem: got %b want 1", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble2: got %b want 0", ex_valid); end
    mem_reg_write = 1'b0; wb_reg_write = 1'b1; wb_reg = 5'd3; wb_data = 64'h77;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", stall); end
    tick();
    wb_reg_write = 1'b0;
    checks++; if (Data1 !== 64'h77 || Data2 !== 64'd5 || Address !== 64'h108 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL lu_latch: got %h %h pc=%h v=%b want 77 5 108 1", Data1, Data2, Address, ex_valid);
    end
    $display("load_use: Data1=%h Data2=%h pc=%h", Data1, Data2, Address);
  endtask

  task automatic test_bypass_cbz();
    if_pc = 64'h10C; if_instr = I_CBZ_X5_M2;
    wb_reg_write = 1'b1; wb_reg = 5'd5; wb_data = 64'hDEAD;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cbz_stall: got %b want 0", stall); end
    tick();
    wb_reg_write = 1'b0;
    checks++; if (Data2 !== 64'hDEAD) begin errors++; $display("FAIL cbz_bypass: got %h want dead", Data2); end
    checks++; if (ctrl !== C_CBZ || signExtInstr !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++; $display("FAIL cbz_ctrl: got %b imm=%h want %b fffffffffffffffe", ctrl, signExtInstr, C_CBZ);
    end
    $display("cbz: Data2=%h ctrl=%b imm=%h", Data2, ctrl, signExtInstr);
  endtask

  task automatic test_stur();
    if_pc = 64'h110; if_instr = I_STUR_X1_X2_16;
    tick();
    checks++; if (Data2 !== 64'd5 || signExtInstr !== 64'd16 || ctrl !== C_STUR) begin
      errors++; $display("FAIL stur: got d2=%h imm=%h ctrl=%b want 5 10 %b", Data2, signExtInstr, ctrl, C_STUR);
    end
    $display("stur: Data2=%h imm=%h ctrl=%b", Data2, signExtInstr, ctrl);
  endtask

  task automatic test_xzr();
    if_valid = 1'b0; wb_reg_write = 1'b1; wb_reg = 5'd31; wb_data = 64'd7;
    tick();
    wb_reg_write = 1'b0;
    if_valid = 1'b1; if_pc = 64'h114; if_instr = I_ADDI_X0_XZR;
    tick();
    checks++; if (Data1 !== 64'd0 || signExtInstr !== 64'd4095 || ctrl !== C_ADDI) begin
      errors++; $display("FAIL addi_xzr: got d1=%h imm=%h ctrl=%b want 0 fff %b", Data1, signExtInstr, ctrl, C_ADDI);
    end
    if_pc = 64'h118; if_instr = I_ADD_XZR_X1_X1;
    tick();
    if_pc = 64'h11C; if_instr = I_ADD_X6_XZR; mem_reg_write = 1'b1; mem_reg = 5'd31;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL xzr_no_stall: got %b want 0", stall); end
    tick();
    mem_reg_write = 1'b0;
    checks++; if (ex_valid !== 1'b1 || Data1 !== 64'd0 || Data2 !== 64'd0) begin
      errors++; $display("FAIL xzr_read: got v=%b %h %h want 1 0 0", ex_valid, Data1, Data2);
    end
    $display("xzr: Data1=%h Data2=%h ex_valid=%b", Data1, Data2, ex_valid);
  endtask

  task automatic test_branch_flush();
    if_pc = 64'h120; if_instr = I_B_M1;
    tick();
    checks++; if (ctrl !== C_B || signExtInstr !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL b_decode: got %b imm=%h want %b all-ones", ctrl, signExtInstr, C_B);
    end
    if_pc = 64'h124; if_instr = I_ADD_X2_X1_X1; mem_reg_write = 1'b1; mem_reg = 5'd1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %b want 1", stall); end
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ctrl !== C_NONE || Instruction !== 32'd0) begin
      errors++; $display("FAIL flush_bubble: got v=%b ctrl=%b ins=%h want bubble", ex_valid, ctrl, Instruction);
    end
    flush = 1'b0; mem_reg_write = 1'b0;
    $display("flush: ex_valid=%b ctrl=%b", ex_valid, ctrl);
  endtask

  task automatic test_illegal();
    if_pc = 64'h128; if_instr = 32'hFFFF_FFFF;
    tick();
    checks++; if (illegal !== 1'b1 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL illegal_set: got ill=%b v=%b want 1 1", illegal, ex_valid);
    end
    checks++; if (ctrl !== C_NONE || signExtInstr !== 64'd0) begin
      errors++; $display("FAIL illegal_ctrl: got %b imm=%h want zeros", ctrl, signExtInstr);
    end
    if_valid = 1'b0;
    tick();
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got %b want 0", illegal); end
    $display("illegal: illegal=%b ctrl=%b", illegal, ctrl);
  endtask

  task automatic test_reset_mid_stall();
    if_valid = 1'b1; if_pc = 64'h12C; if_instr = I_ADD_X4_X3_X1; mem_reg_write = 1'b1; mem_reg = 5'd3;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %b want 1", stall); end
    reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall: got %b want 0", stall); end
    tick();
    reset = 1'b0; mem_reg_write = 1'b0;
    if_pc = 64'h130; if_instr = I_ADD_X2_X1_X1;
    tick();
    checks++; if (Data1 !== 64'd0 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL regfile_cleared: got d1=%h v=%b want 0 1", Data1, ex_valid);
    end
    $display("reset_mid_stall: Data1=%h ex_valid=%b", Data1, ex_valid);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_writeback_add();
    test_load_use();
    test_bypass_cbz();
    test_stur();
    test_xzr();
    test_branch_flush();
    test_illegal();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
